// File: rtl/aes_mixcol_iter.sv
// aes_mixcol_iter: iterative AES MixColumns / InvMixColumns over an NB-column
// state, transforming CPC columns per clock, with valid/ready on both sides.
module aes_mixcol_iter #(
    parameter int NB  = 4,
    parameter int CPC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_mode,
    input  logic [7:0] State_in  [0:4*NB-1],
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] State_out [0:4*NB-1],
    output logic       busy
);
    // Number of column groups; the counter holds the group index, so the
    // first column of the active group is grp*CPC (never beyond NB-CPC).
    localparam int NG = NB / CPC;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] grp, grp_next;
    logic          mode, mode_next;
    logic [7:0]    work      [0:4*NB-1];
    logic [7:0]    work_next [0:4*NB-1];

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant below 16 by summing the xtime chain b, 2b, 4b, 8b.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Transform one column; row 0 sits in bits [31:24].
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [3:0]  coef [0:3];
        logic [7:0]  a    [0:3];
        logic [7:0]  o;
        logic [1:0]  idx;
        logic [31:0] res;
        if (inv) begin
            coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
        end else begin
            coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
        end
        for (int k = 0; k < 4; k++) begin
            a[k] = c[31-8*k -: 8];
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            o = 8'h00;
            for (int k = 0; k < 4; k++) begin
                idx = 2'(k - r);
                o   = o ^ gmul(a[k], coef[idx]);
            end
            res[31-8*r -: 8] = o;
        end
        return res;
    endfunction

    // Next-state logic, handshake outputs and the in-place group transform.
    always_comb begin
        logic [31:0] col;
        state_next = state;
        grp_next   = grp;
        mode_next  = mode;
        work_next  = work;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        col        = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_next  = State_in;
                    mode_next  = in_mode;
                    grp_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                for (int c = 0; c < CPC; c++) begin
                    col = '0;
                    for (int gi = 0; gi < NG; gi++) begin
                        if (grp == CW'(gi)) begin
                            col = {work[4*(gi*CPC+c)],   work[4*(gi*CPC+c)+1],
                                   work[4*(gi*CPC+c)+2], work[4*(gi*CPC+c)+3]};
                        end
                    end
                    col = mix_col(col, mode);
                    for (int gi = 0; gi < NG; gi++) begin
                        if (grp == CW'(gi)) begin
                            for (int r = 0; r < 4; r++) begin
                                work_next[4*(gi*CPC+c)+r] = col[31-8*r -: 8];
                            end
                        end
                    end
                end
                if (grp == CW'(NG - 1)) begin
                    state_next = DONE;
                end else begin
                    grp_next = grp + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result is only visible while holding it in DONE.
    always_comb begin
        for (int i = 0; i < 4*NB; i++) begin
            State_out[i] = (state == DONE) ? work[i] : 8'h00;
        end
    end

    // State, counter, latched mode and working register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grp   <= '0;
            mode  <= 1'b0;
            for (int i = 0; i < 4*NB; i++) begin
                work[i] <= 8'h00;
            end
        end else begin
            state <= state_next;
            grp   <= grp_next;
            mode  <= mode_next;
            work  <= work_next;
        end
    end
endmodule
